dmem_responder: RTL

Data-memory responder on the far end of the pipeline's memory-stage interface. The datapath issues address, write data and byte enables. This block serves each request after a programmable number of wait states and returns read data plus a busy signal for the hazard unit to stall on. The word-addressed storage array is internal, and each request has one outstanding transaction.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-stage interface: serves one request at a time
// after LAT wait states and raises busy so the hazard unit can stall the M stage.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [3:0]     cnt;
    logic           holdWe;
    logic           holdErr;
    logic [AW-1:0]  holdIdx;
    logic [31:0]    holdWdata;
    logic [3:0]     holdBe;

    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           doAccess;
    logic           addrErr;
    logic [31:0]    curWord;
    logic [31:0]    mergedWord;
    logic [31:0]    respWord;
    logic           unusedAddrBits;

    // Range check uses the full word index, not just the bits that address the array.
    assign addrErr        = {2'b00, req_addr[31:2]} >= 32'(DEPTH);
    assign unusedAddrBits = ^req_addr[1:0];
    assign curWord        = mem[holdIdx];
    assign dbgState       = state;

    always_comb begin
        mergedWord = curWord;
        for (int i = 0; i < 4; i++) begin
            if (holdBe[i]) begin
                mergedWord[8*i +: 8] = holdWdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        if (holdErr) begin
            respWord = 32'h0;
        end else if (holdWe) begin
            respWord = mergedWord;
        end else begin
            respWord = curWord;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b1;
        accept    = 1'b0;
        doAccess  = 1'b0;
        case (state)
            IDLE: begin
                busy   = req_valid;
                accept = req_valid;
                if (req_valid) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    doAccess  = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            holdWe     <= 1'b0;
            holdErr    <= 1'b0;
            holdIdx    <= '0;
            holdWdata  <= 32'h0;
            holdBe     <= 4'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state      <= nextState;
            resp_valid <= doAccess;
            if (accept) begin
                cnt       <= 4'(LAT - 1);
                holdWe    <= req_we;
                holdErr   <= addrErr;
                holdIdx   <= req_addr[AW+1:2];
                holdWdata <= req_wdata;
                holdBe    <= req_be;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (doAccess) begin
                resp_rdata <= respWord;
                resp_err   <= holdErr;
            end
        end
    end

    // No reset on the array; doAccess is low while in reset, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (doAccess && holdWe && !holdErr) begin
            mem[holdIdx] <= mergedWord;
        end
    end

endmodule
